idma_inoc_ibuffer_bank_arbiter: RTL and testbench



---
 rtl/idma_inoc_ibuffer_bank_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_idma_inoc_ibuffer_bank_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idma_inoc_ibuffer_bank_arbiter.sv
// Multi-bank ibuffer arbiter: the iDMA fills one bank while the iNoC drains another.
// Per-bank FREE/FILL/FULL/DRAIN state; round-robin fill/drain pointers.
module idma_inoc_ibuffer_bank_arbiter #(
  parameter int DATA_WIDTH      = 128,
  parameter int MEM_AW          = 15,
  parameter int STRB_WIDTH      = DATA_WIDTH / 8,
  parameter int NUM_BANKS       = 2,
  parameter int MAX_OUTSTANDING = 8,
  localparam int BW = $clog2(NUM_BANKS),
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             dma_read_start,
  input  logic                             dma_write_done,
  input  logic                             noc_read_done,
  input  logic                             dma_read_to_ibuffer_cen,
  input  logic                             dma_read_to_ibuffer_wen,
  output logic                             dma_read_to_ibuffer_ready,
  input  logic [MEM_AW-1:0]                dma_read_to_ibuffer_addr,
  input  logic [DATA_WIDTH-1:0]            dma_read_to_ibuffer_wdata,
  input  logic [STRB_WIDTH-1:0]            dma_read_to_ibuffer_strb,
  input  logic                             noc_read_from_ibuffer_cen,
  input  logic                             noc_read_from_ibuffer_wen,
  output logic                             noc_read_from_ibuffer_ready,
  input  logic [MEM_AW-1:0]                noc_read_from_ibuffer_addr,
  output logic [DATA_WIDTH-1:0]            noc_read_from_ibuffer_rdata,
  output logic                             noc_read_from_ibuffer_rvalid,
  input  logic                             noc_read_from_ibuffer_rready,
  output logic [NUM_BANKS-1:0]             bank_cen,
  output logic [NUM_BANKS-1:0]             bank_wen,
  input  logic [NUM_BANKS-1:0]             bank_ready,
  output logic [NUM_BANKS*MEM_AW-1:0]      bank_addr,
  output logic [NUM_BANKS*DATA_WIDTH-1:0]  bank_wdata,
  output logic [NUM_BANKS*STRB_WIDTH-1:0]  bank_strb,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0]  bank_rdata,
  input  logic [NUM_BANKS-1:0]             bank_rvalid,
  output logic [NUM_BANKS-1:0]             bank_rready,
  output logic [BW-1:0]                    fill_ptr,
  output logic [BW-1:0]                    drain_ptr,
  output logic                             dma_bank_avail,
  output logic                             noc_bank_avail,
  output logic                             err_pulse
);

  localparam logic [1:0] ST_FREE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic [NUM_BANKS-1:0][1:0] state_r, state_n;
  logic [BW-1:0]             fill_ptr_r, fill_ptr_n, drain_ptr_r, drain_ptr_n, next_fill_s;
  logic [CW-1:0]             outstanding_r, outstanding_n;
  logic                      release_pending_r, release_pending_n;
  logic                      err_r, err_n;

  logic [1:0] fill_state_s, drain_state_s, claim_state_s;
  logic       drain_ok_s, noc_gate_s, noc_accept_s, rsp_s, release_s, done_ok_s;
  logic       err_start_s, err_done_s, err_noc_done_s, err_wen_s;

  assign fill_state_s  = state_r[fill_ptr_r];
  assign drain_state_s = state_r[drain_ptr_r];
  assign next_fill_s   = fill_ptr_r + BW'(1);
  assign drain_ok_s    = (drain_state_s == ST_FULL) || (drain_state_s == ST_DRAIN);
  // No new reads while a release waits for in-flight responses to return.
  assign noc_gate_s    = drain_ok_s && (outstanding_r < CW'(MAX_OUTSTANDING)) &&
                         !release_pending_r && !noc_read_from_ibuffer_wen;
  assign noc_accept_s  = noc_read_from_ibuffer_cen && noc_read_from_ibuffer_ready;
  assign rsp_s         = bank_rvalid[drain_ptr_r] && noc_read_from_ibuffer_rready &&
                         (outstanding_r != CW'(0));
  assign done_ok_s     = dma_write_done && (fill_state_s == ST_FILL);

  assign dma_read_to_ibuffer_ready   = (fill_state_s == ST_FILL) && bank_ready[fill_ptr_r];
  assign noc_read_from_ibuffer_ready = noc_gate_s && bank_ready[drain_ptr_r];
  assign noc_read_from_ibuffer_rdata = bank_rdata[drain_ptr_r*DATA_WIDTH +: DATA_WIDTH];
  assign noc_read_from_ibuffer_rvalid = bank_rvalid[drain_ptr_r] && rst_n;

  assign fill_ptr       = fill_ptr_r;
  assign drain_ptr      = drain_ptr_r;
  assign dma_bank_avail = (fill_state_s == ST_FREE);
  assign noc_bank_avail = drain_ok_s;
  assign err_pulse      = err_r;

  // Route the DMA port to the fill bank and the NoC port to the drain bank.
  always_comb begin
    bank_cen    = '0;
    bank_wen    = '0;
    bank_addr   = '0;
    bank_wdata  = '0;
    bank_strb   = '0;
    bank_rready = '1;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if ((fill_ptr_r == BW'(b)) && (fill_state_s == ST_FILL)) begin
        bank_cen[b]                           = dma_read_to_ibuffer_cen;
        bank_wen[b]                           = dma_read_to_ibuffer_wen;
        bank_addr[b*MEM_AW +: MEM_AW]         = dma_read_to_ibuffer_addr;
        bank_wdata[b*DATA_WIDTH +: DATA_WIDTH] = dma_read_to_ibuffer_wdata;
        bank_strb[b*STRB_WIDTH +: STRB_WIDTH] = dma_read_to_ibuffer_strb;
      end else if ((drain_ptr_r == BW'(b)) && noc_gate_s) begin
        bank_cen[b]                   = noc_read_from_ibuffer_cen;
        bank_addr[b*MEM_AW +: MEM_AW] = noc_read_from_ibuffer_addr;
      end else begin
        bank_cen[b] = 1'b0;
      end
      if (drain_ptr_r == BW'(b)) begin
        bank_rready[b] = noc_read_from_ibuffer_rready;
      end else begin
        bank_rready[b] = 1'b1;
      end
    end
  end

  // Bank state, pointer, outstanding-count and error next-state logic.
  always_comb begin
    state_n           = state_r;
    fill_ptr_n        = fill_ptr_r;
    drain_ptr_n       = drain_ptr_r;
    release_pending_n = release_pending_r;
    claim_state_s     = fill_state_s;
    release_s         = 1'b0;
    case ({noc_accept_s, rsp_s})
      2'b10:   outstanding_n = outstanding_r + CW'(1);
      2'b01:   outstanding_n = outstanding_r - CW'(1);
      default: outstanding_n = outstanding_r;
    endcase

    if (release_pending_r) begin
      release_s = (outstanding_r == CW'(0));
    end else if (noc_read_done && drain_ok_s) begin
      release_s = (outstanding_r == CW'(0)) && !noc_accept_s;
    end else begin
      release_s = 1'b0;
    end
    if (noc_read_done && drain_ok_s && !release_pending_r && !release_s) begin
      release_pending_n = 1'b1;
    end else begin
      release_pending_n = release_pending_r;
    end

    if (noc_accept_s && (drain_state_s == ST_FULL)) begin
      state_n[drain_ptr_r] = ST_DRAIN;
    end else if (release_s) begin
      state_n[drain_ptr_r] = ST_FREE;
      drain_ptr_n          = drain_ptr_r + BW'(1);
      release_pending_n    = 1'b0;
    end else begin
      drain_ptr_n = drain_ptr_r;
    end

    // A same-cycle start evaluates the bank after the one just completed.
    if (done_ok_s) begin
      state_n[fill_ptr_r] = ST_FULL;
      fill_ptr_n          = next_fill_s;
      claim_state_s       = state_r[next_fill_s];
    end else begin
      fill_ptr_n = fill_ptr_r;
    end
    if (dma_read_start && (claim_state_s == ST_FREE)) begin
      state_n[fill_ptr_n] = ST_FILL;
    end else begin
      claim_state_s = claim_state_s;
    end

    err_start_s    = dma_read_start && (claim_state_s != ST_FREE);
    err_done_s     = dma_write_done && (fill_state_s != ST_FILL);
    err_noc_done_s = noc_read_done && !drain_ok_s;
    err_wen_s      = noc_read_from_ibuffer_cen && noc_read_from_ibuffer_wen;
    err_n          = err_start_s || err_done_s || err_noc_done_s || err_wen_s;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r           <= '0;
      fill_ptr_r        <= '0;
      drain_ptr_r       <= '0;
      outstanding_r     <= '0;
      release_pending_r <= 1'b0;
      err_r             <= 1'b0;
    end else begin
      state_r           <= state_n;
      fill_ptr_r        <= fill_ptr_n;
      drain_ptr_r       <= drain_ptr_n;
      outstanding_r     <= outstanding_n;
      release_pending_r <= release_pending_n;
      err_r             <= err_n;
    end
  end

endmodule

// File: tb/tb_idma_inoc_ibuffer_bank_arbiter.sv
// Directed bench for idma_inoc_ibuffer_bank_arbiter with two behavioural bank macros
// (1-cycle read latency, response FIFO so rready back-pressure is honoured).
module tb_idma_inoc_ibuffer_bank_arbiter;
  localparam int DW = 128;
  localparam int AW = 15;
  localparam int SW = 16;
  localparam int NB = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic dma_read_start, dma_write_done, noc_read_done;
  logic dma_cen, dma_wen, noc_cen, noc_wen, noc_rready;
  logic [AW-1:0] dma_addr, noc_addr;
  logic [DW-1:0] dma_wdata;
  logic [SW-1:0] dma_strb;
  logic [NB-1:0] bank_ready;
  wire dma_ready, noc_ready, noc_rvalid, dma_bank_avail, noc_bank_avail, err_pulse;
  wire [DW-1:0] noc_rdata;
  wire [NB-1:0] bank_cen, bank_wen, bank_rready, bank_rvalid;
  wire [NB*AW-1:0] bank_addr;
  wire [NB*DW-1:0] bank_wdata, bank_rdata;
  wire [NB*SW-1:0] bank_strb;
  wire [0:0] fill_ptr, drain_ptr;

  idma_inoc_ibuffer_bank_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .dma_read_start(dma_read_start), .dma_write_done(dma_write_done), .noc_read_done(noc_read_done),
    .dma_read_to_ibuffer_cen(dma_cen), .dma_read_to_ibuffer_wen(dma_wen),
    .dma_read_to_ibuffer_ready(dma_ready), .dma_read_to_ibuffer_addr(dma_addr),
    .dma_read_to_ibuffer_wdata(dma_wdata), .dma_read_to_ibuffer_strb(dma_strb),
    .noc_read_from_ibuffer_cen(noc_cen), .noc_read_from_ibuffer_wen(noc_wen),
    .noc_read_from_ibuffer_ready(noc_ready), .noc_read_from_ibuffer_addr(noc_addr),
    .noc_read_from_ibuffer_rdata(noc_rdata), .noc_read_from_ibuffer_rvalid(noc_rvalid),
    .noc_read_from_ibuffer_rready(noc_rready),
    .bank_cen(bank_cen), .bank_wen(bank_wen), .bank_ready(bank_ready), .bank_addr(bank_addr),
    .bank_wdata(bank_wdata), .bank_strb(bank_strb), .bank_rdata(bank_rdata),
    .bank_rvalid(bank_rvalid), .bank_rready(bank_rready),
    .fill_ptr(fill_ptr), .drain_ptr(drain_ptr),
    .dma_bank_avail(dma_bank_avail), .noc_bank_avail(noc_bank_avail), .err_pulse(err_pulse)
  );

  for (genvar b = 0; b < NB; b++) begin : g_bank
    logic [DW-1:0] mem [16];
    logic [DW-1:0] q [16];
    logic [4:0] wp, rp;
    assign bank_rvalid[b] = (wp != rp);
    assign bank_rdata[b*DW +: DW] = q[rp[3:0]];
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wp <= 5'd0;
        rp <= 5'd0;
      end else begin
        if (bank_cen[b] && bank_ready[b]) begin
          if (bank_wen[b]) begin
            for (int j = 0; j < SW; j++)
              if (bank_strb[b*SW+j]) mem[bank_addr[b*AW +: 4]][j*8 +: 8] <= bank_wdata[b*DW + j*8 +: 8];
          end else begin
            q[wp[3:0]] <= mem[bank_addr[b*AW +: 4]];
            wp <= wp + 5'd1;
          end
        end
        if (bank_rvalid[b] && bank_rready[b]) rp <= rp + 5'd1;
      end
    end
  end

  int passed = 0, total = 0, fails = 0, rsp_cnt = 0, stall = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] noc_exp;

  function automatic logic [DW-1:0] pat(input logic [15:0] tag, input int idx);
    logic [15:0] i16;
    i16 = idx[15:0];
    return {4{tag, i16}};
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Settle, scoreboard the NoC handshakes of this cycle, then advance one clock.
  task automatic tick;
    #1;
    if (noc_cen && noc_ready) exp_q.push_back(noc_exp);
    if (noc_rvalid && noc_rready) begin
      total++;
      assert (exp_q.size() != 0) passed++;
      else begin
        fails++;
        $error("FAIL unexpected_rsp: observed response expected none");
      end
      if (exp_q.size() != 0) chk("noc_rdata", noc_rdata, exp_q.pop_front());
      rsp_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; dma_read_start = 1'b0; dma_write_done = 1'b0; noc_read_done = 1'b0;
    dma_cen = 1'b0; dma_wen = 1'b0; dma_addr = '0; dma_wdata = '0; dma_strb = '1;
    noc_cen = 1'b0; noc_wen = 1'b0; noc_addr = '0; noc_rready = 1'b1; noc_exp = '0;
    bank_ready = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fill_ptr", fill_ptr, 0);
    chk("rst_drain_ptr", drain_ptr, 0);
    chk("rst_dma_avail", dma_bank_avail, 1);
    chk("rst_noc_avail", noc_bank_avail, 0);
    chk("rst_err", err_pulse, 0);
    chk("rst_noc_ready", noc_ready, 0);
    rst_n = 1'b1;
    tick;

    // Fill bank0 with 16 words.
    dma_read_start = 1'b1; tick; dma_read_start = 1'b0;
    chk("claim_dma_ready", dma_ready, 1);
    chk("claim_dma_avail", dma_bank_avail, 0);
    for (int i = 0; i < 16; i++) begin
      dma_cen = 1'b1; dma_wen = 1'b1; dma_addr = AW'(i); dma_wdata = pat(16'hA0A0, i);
      if (!dma_ready) stall++;
      tick;
    end
    dma_cen = 1'b0; dma_wen = 1'b0;
    dma_write_done = 1'b1; tick; dma_write_done = 1'b0;
    chk("fill0_fill_ptr", fill_ptr, 1);
    chk("fill0_drain_ptr", drain_ptr, 0);
    chk("fill0_noc_avail", noc_bank_avail, 1);
    chk("fill0_dma_avail", dma_bank_avail, 1);
    chk("fill0_mem5", g_bank[0].mem[5], pat(16'hA0A0, 5));

    // Ping-pong: drain bank0 while filling bank1.
    dma_read_start = 1'b1; tick; dma_read_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      dma_cen = 1'b1; dma_wen = 1'b1; dma_addr = AW'(i); dma_wdata = pat(16'hB1B1, i);
      noc_cen = 1'b1; noc_addr = AW'(i); noc_exp = pat(16'hA0A0, i);
      if (!dma_ready || !noc_ready) stall++;
      tick;
    end
    dma_cen = 1'b0; dma_wen = 1'b0; noc_cen = 1'b0;
    tick;
    chk("pingpong_stalls", stall, 0);
    chk("pingpong_rsp_cnt", rsp_cnt, 16);
    dma_write_done = 1'b1; noc_read_done = 1'b1; tick;
    dma_write_done = 1'b0; noc_read_done = 1'b0;
    chk("pp_drain_ptr", drain_ptr, 1);
    chk("pp_fill_ptr", fill_ptr, 0);
    chk("pp_dma_avail", dma_bank_avail, 1);
    chk("pp_noc_avail", noc_bank_avail, 1);
    chk("pp_err", err_pulse, 0);

    // Release requested with 3 reads in flight.
    noc_rready = 1'b0; rsp_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      noc_cen = 1'b1; noc_addr = AW'(i); noc_exp = pat(16'hB1B1, i);
      tick;
    end
    noc_cen = 1'b0;
    noc_read_done = 1'b1; tick; noc_read_done = 1'b0;
    chk("pend_noc_ready", noc_ready, 0);
    chk("pend_drain_ptr", drain_ptr, 1);
    chk("pend_rvalid", noc_rvalid, 1);
    noc_rready = 1'b1;
    tick; tick; tick;
    chk("pend_no_early_release", drain_ptr, 1);
    tick;
    chk("pend_released", drain_ptr, 0);
    chk("pend_rsp_cnt", rsp_cnt, 3);

    // Outstanding limit: 8 reads with rready low.
    dma_read_start = 1'b1; tick; dma_read_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      dma_cen = 1'b1; dma_wen = 1'b1; dma_addr = AW'(i); dma_wdata = pat(16'hC2C2, i);
      tick;
    end
    dma_cen = 1'b0; dma_wen = 1'b0;
    dma_write_done = 1'b1; tick; dma_write_done = 1'b0;
    noc_rready = 1'b0; rsp_cnt = 0; stall = 0;
    for (int i = 0; i < 8; i++) begin
      noc_cen = 1'b1; noc_addr = AW'(i); noc_exp = pat(16'hC2C2, i);
      if (!noc_ready) stall++;
      tick;
    end
    chk("max_stalls", stall, 0);
    noc_addr = '0; noc_exp = pat(16'hC2C2, 0);
    chk("max_ready_low", noc_ready, 0);
    tick;
    noc_rready = 1'b1;
    tick;
    chk("max_ready_resume", noc_ready, 1);
    tick;
    noc_cen = 1'b0;
    repeat (12) tick;
    chk("max_rsp_cnt", rsp_cnt, 9);
    chk("max_q_empty", exp_q.size(), 0);
    noc_read_done = 1'b1; tick; noc_read_done = 1'b0;
    chk("max_drain_ptr", drain_ptr, 1);

    // Both banks FULL: start must error without claiming.
    dma_read_start = 1'b1; tick; dma_read_start = 1'b0;
    dma_write_done = 1'b1; tick; dma_write_done = 1'b0;
    dma_read_start = 1'b1; tick; dma_read_start = 1'b0;
    dma_write_done = 1'b1; tick; dma_write_done = 1'b0;
    dma_read_start = 1'b1; tick; dma_read_start = 1'b0;
    chk("full_err", err_pulse, 1);
    chk("full_fill_ptr", fill_ptr, 1);
    chk("full_dma_ready", dma_ready, 0);
    tick;
    chk("full_err_once", err_pulse, 0);
    noc_cen = 1'b1; noc_wen = 1'b1;
    #1;
    chk("wen_noc_ready", noc_ready, 0);
    tick;
    noc_cen = 1'b0; noc_wen = 1'b0;
    chk("wen_err", err_pulse, 1);

    // Same-cycle done + start claims the next FREE bank.
    noc_read_done = 1'b1; tick; noc_read_done = 1'b0;
    dma_read_start = 1'b1; tick; dma_read_start = 1'b0;
    noc_read_done = 1'b1; tick; noc_read_done = 1'b0;
    dma_write_done = 1'b1; dma_read_start = 1'b1; tick;
    dma_write_done = 1'b0; dma_read_start = 1'b0;
    chk("ds_fill_ptr", fill_ptr, 0);
    chk("ds_err", err_pulse, 0);
    chk("ds_dma_ready", dma_ready, 1);
    chk("ds_noc_avail", noc_bank_avail, 1);

    // Reset during a fill and a drain with a response pending.
    noc_rready = 1'b0;
    dma_cen = 1'b1; dma_wen = 1'b1; dma_addr = '0; dma_wdata = pat(16'hD3D3, 0);
    noc_cen = 1'b1; noc_addr = '0; noc_exp = pat(16'hB1B1, 0);
    tick;
    noc_cen = 1'b0;
    tick;
    chk("prerst_rvalid", noc_rvalid, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_fill_ptr", fill_ptr, 0);
    chk("midrst_drain_ptr", drain_ptr, 0);
    chk("midrst_rvalid", noc_rvalid, 0);
    chk("midrst_dma_ready", dma_ready, 0);
    chk("midrst_bank_cen", bank_cen, 0);
    chk("midrst_dma_avail", dma_bank_avail, 1);
    chk("midrst_noc_avail", noc_bank_avail, 0);
    dma_cen = 1'b0; dma_wen = 1'b0; noc_rready = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick;

    // Fresh fill and drain after reset.
    dma_read_start = 1'b1; tick; dma_read_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      dma_cen = 1'b1; dma_wen = 1'b1; dma_addr = AW'(i); dma_wdata = pat(16'hE4E4, i);
      tick;
    end
    dma_cen = 1'b0; dma_wen = 1'b0;
    dma_write_done = 1'b1; tick; dma_write_done = 1'b0;
    rsp_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      noc_cen = 1'b1; noc_addr = AW'(i); noc_exp = pat(16'hE4E4, i);
      tick;
    end
    noc_cen = 1'b0;
    tick; tick;
    chk("fresh_rsp_cnt", rsp_cnt, 2);
    noc_read_done = 1'b1; tick; noc_read_done = 1'b0;
    chk("fresh_drain_ptr", drain_ptr, 1);
    chk("fresh_fill_ptr", fill_ptr, 1);
    chk("fresh_noc_avail", noc_bank_avail, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
